aes_round_sequencer: RTL and testbench

//  Owns the 128-bit AES state and drives the 32-bit masked round datapath (AesDataPath) one column per cycle.
//  - The datapath does not perform ShiftRows. This block applies ShiftRows (or InvShiftRows) when it gathers

---
 rtl/aes_seq_pkg.sv | 16 +
 rtl/aes_shift_gather.sv | 14 +
 rtl/aes_round_sequencer.sv | 104 ++++++++++
 tb/tb_aes_round_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared FSM type, key-length encodings and index helpers for the AES round sequencer
package aes_seq_pkg;
  localparam int RK_IDX_BITS = 6;
  localparam int ROUND_BITS = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seqState_t;
  typedef enum logic [1:0] {KEY_128 = 2'd0, KEY_192 = 2'd1, KEY_256 = 2'd2, KEY_RSVD = 2'd3} keyLen_t;
  function automatic logic [ROUND_BITS-1:0] nr_of(input logic [1:0] keyLen);
    return keyLen == KEY_192 ? 4'd12 : keyLen == KEY_256 ? 4'd14 : 4'd10;
  endfunction
  function automatic logic [RK_IDX_BITS-1:0] rk_index(input logic dec, input logic [ROUND_BITS-1:0] round,
                                                      input logic [ROUND_BITS-1:0] nr, input logic [1:0] col);
    logic [ROUND_BITS-1:0] r;
    r = dec ? nr - round : round;
    return {r, col};
  endfunction
endpackage

// File: rtl/aes_shift_gather.sv
// aes_shift_gather: picks one (Inv)ShiftRows-ed column out of the 128-bit state
module aes_shift_gather (
  input  logic [127:0] stateIn,
  input  logic [1:0]   col,
  input  logic         dec,
  input  logic         bypass,
  output logic [31:0]  colOut
);
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [1:0] src;
    assign src = bypass ? col : dec ? col - 2'(r) : col + 2'(r);
    assign colOut[31-8*r -: 8] = stateIn[127-32*src-8*r -: 8];
  end
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: owns the AES state and feeds the masked column datapath one column per cycle
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int RK_IDX_W = RK_IDX_BITS,
  parameter int ROUND_W = ROUND_BITS
) (
  input  logic                Clk,
  input  logic                Resetn,
  input  logic                InValid,
  output logic                InReady,
  input  logic [127:0]        InBlock,
  input  logic                InDec,
  input  logic [1:0]          KeyLen,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [127:0]        OutBlock,
  output logic                Busy,
  output logic [RK_IDX_W-1:0] RkIdx,
  input  logic [31:0]         RkWord,
  input  logic [31:0]         MaskIn,
  output logic [31:0]         DpDataIn,
  output logic [31:0]         DpMaskIn,
  output logic [31:0]         DpRoundKey,
  output logic                DpEnc,
  output logic                DpDec,
  output logic                DpKeyEn,
  output logic                DpFirst,
  output logic                DpLast,
  input  logic [31:0]         DpDataOut
);
  seqState_t fsm, fsmNext;
  logic [127:0] state;
  logic [31:0] nextBuf [3];
  logic [ROUND_W-1:0] round, nr;
  logic [1:0] col;
  logic dec, run, accept, lastCol;

  assign accept = InValid && InReady;
  assign lastCol = col == 2'd3 && round == nr;
  assign run = fsm == RUN;
  assign DpMaskIn = MaskIn;
  assign DpRoundKey = RkWord;
  assign DpKeyEn = 1'b0;

  aes_shift_gather u_gather (
    .stateIn(state),
    .col(col),
    .dec(dec),
    .bypass(round == '0),
    .colOut(DpDataIn)
  );

  // state register
  always_ff @(posedge Clk) fsm <= Resetn ? fsmNext : IDLE;

  // next-state: accept -> run all columns of all rounds -> hold result until consumed
  always_comb begin
    fsmNext = fsm;
    case (fsm)
      IDLE: fsmNext = accept ? RUN : IDLE;
      RUN: fsmNext = lastCol ? DONE : RUN;
      DONE: fsmNext = OutReady ? IDLE : DONE;
      default: fsmNext = IDLE;
    endcase
  end

  // handshakes, datapath strobes and result are gated by FSM state so nothing leaks outside DONE
  always_comb begin
    InReady = fsm == IDLE && Resetn;
    OutValid = fsm == DONE;
    Busy = fsm != IDLE;
    OutBlock = fsm == DONE ? state : '0;
    DpEnc = run && !dec;
    DpDec = run && dec;
    DpFirst = run && round == '0;
    DpLast = run && round == nr;
    RkIdx = run ? rk_index(dec, round, nr, col) : '0;
  end

  // capture on accept; buffer columns 0..2 so the gather keeps reading the old state until column 3
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state <= '0;
      nextBuf <= '{default: '0};
      round <= '0;
      nr <= '0;
      col <= '0;
      dec <= 1'b0;
    end else if (accept) begin
      state <= InBlock;
      dec <= InDec;
      nr <= nr_of(KeyLen);
      round <= '0;
      col <= '0;
    end else if (run) begin
      if (col == 2'd3) begin
        state <= {nextBuf[0], nextBuf[1], nextBuf[2], DpDataOut};
        round <= round + 1'b1;
      end else nextBuf[col] <= DpDataOut;
      col <= col + 1'b1;
    end
  end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: scoreboard bench with behavioural column datapath and key schedule
`timescale 1ns/1ps
module tb_aes_round_sequencer;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic Clk = 0, Resetn = 0, InValid = 0, InDec = 0, OutReady = 1;
  logic [127:0] InBlock = '0;
  logic [1:0] KeyLen = '0;
  logic InReady, OutValid, Busy, DpEnc, DpDec, DpKeyEn, DpFirst, DpLast;
  logic [127:0] OutBlock;
  logic [5:0] RkIdx;
  logic [31:0] RkWord, MaskIn, DpDataIn, DpMaskIn, DpRoundKey, DpDataOut;
  logic [31:0] lfsr = 32'h1badb002;
  int maskMode = 0;
  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] sbox [256], isbox [256];
  logic [31:0] w [60];
  typedef struct { int id; logic [127:0] blk; int lat; int acc; } exp_t;
  exp_t sb [$];
  logic [5:0] rkLog [$];
  bit seen = 0;

  aes_round_sequencer dut (
    .Clk(Clk), .Resetn(Resetn), .InValid(InValid), .InReady(InReady), .InBlock(InBlock),
    .InDec(InDec), .KeyLen(KeyLen), .OutValid(OutValid), .OutReady(OutReady), .OutBlock(OutBlock),
    .Busy(Busy), .RkIdx(RkIdx), .RkWord(RkWord), .MaskIn(MaskIn), .DpDataIn(DpDataIn),
    .DpMaskIn(DpMaskIn), .DpRoundKey(DpRoundKey), .DpEnc(DpEnc), .DpDec(DpDec), .DpKeyEn(DpKeyEn),
    .DpFirst(DpFirst), .DpLast(DpLast), .DpDataOut(DpDataOut)
  );

  always #5 Clk = ~Clk;

  // cycle counter used for latency measurement
  always @(posedge Clk) cyc <= cyc + 1;

  // mask source: zero, all ones, or a fresh LFSR word every cycle
  always @(negedge Clk) lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign MaskIn = maskMode == 0 ? 32'h0 : maskMode == 1 ? 32'hffffffff : lfsr;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x, input logic inv);
    return inv ? {isbox[x[31:24]], isbox[x[23:16]], isbox[x[15:8]], isbox[x[7:0]]}
               : {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] x, input logic inv);
    logic [7:0] m [4];
    logic [31:0] y;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else m = '{8'h02, 8'h03, 8'h01, 8'h01};
    y = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        y[31-8*i -: 8] = y[31-8*i -: 8] ^ gmul(m[(j - i + 4) % 4], x[31-8*j -: 8]);
    return y;
  endfunction

  // behavioural column datapath (mask already removed): round 0 is AddRoundKey only
  always_comb begin
    DpDataOut = DpDataIn ^ DpRoundKey;
    if (DpEnc && !DpFirst)
      DpDataOut = DpLast ? subw(DpDataIn, 1'b0) ^ DpRoundKey : mixw(subw(DpDataIn, 1'b0), 1'b0) ^ DpRoundKey;
    if (DpDec && !DpFirst)
      DpDataOut = DpLast ? subw(DpDataIn, 1'b1) ^ DpRoundKey : mixw(subw(DpDataIn, 1'b1) ^ DpRoundKey, 1'b1);
  end

  assign RkWord = RkIdx < 6'd60 ? w[RkIdx] : 32'h0;

  task automatic initTables;
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  // FIPS-197 key expansion for the sequential-byte keys 00 01 02 ...
  task automatic expandKey(input int nk);
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}, 1'b0) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk == 8 && i % nk == 4) t = subw(t, 1'b0);
        w[i] = w[i-nk] ^ t;
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  // scoreboard monitor: pops the expectation when a result first appears
  always @(negedge Clk) begin
    exp_t e;
    if (!Resetn) seen = 0;
    else if (OutValid) begin
      if (!seen) begin
        if (sb.size() == 0) chk("unexpected_out_queue", 128'(sb.size()), 128'd1);
        else begin
          e = sb.pop_front();
          chk($sformatf("t%0d_block", e.id), OutBlock, e.blk);
          chk($sformatf("t%0d_latency", e.id), 128'(cyc - e.acc), 128'(e.lat));
        end
      end
      seen = !OutReady;
    end
  end

  // log of round-key indices requested during decryption
  always @(negedge Clk) if (DpDec) rkLog.push_back(RkIdx);

  task automatic send(input int id, input logic [127:0] blk, input logic dec, input logic [1:0] kl,
                      input logic [127:0] exp, input bit push, input bit noise);
    int n, nr;
    n = 0;
    nr = kl == 2'd1 ? 12 : kl == 2'd2 ? 14 : 10;
    while (!InReady && n < 300) begin step(); n++; end
    chk($sformatf("t%0d_ready", id), 128'(InReady), 128'd1);
    InBlock = blk;
    InDec = dec;
    KeyLen = kl;
    InValid = 1;
    if (push) sb.push_back('{id, exp, 4 * (nr + 1) + 1, cyc});
    step();
    InValid = 0;
    if (noise) begin
      InValid = 1;
      InDec = !dec;
      KeyLen = ~kl;
      InBlock = ~blk;
      repeat (10) step();
      InValid = 0;
    end
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while ((sb.size() != 0 || Busy) && n < 200) begin step(); n++; end
    chk($sformatf("t%0d_done_in_time", id), 128'(n < 200), 128'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int n;
    initTables();
    expandKey(4);
    repeat (3) step();
    chk("rst_inready", 128'(InReady), 128'd0);
    chk("rst_outvalid", 128'(OutValid), 128'd0);
    chk("rst_outblock", OutBlock, 128'd0);
    chk("rst_busy", 128'(Busy), 128'd0);
    chk("rst_rkidx", 128'(RkIdx), 128'd0);
    chk("rst_dp_strobes", 128'({DpEnc, DpDec, DpKeyEn}), 128'd0);
    Resetn = 1;
    step();
    send(1, PT, 1'b0, 2'd0, CT128, 1, 0);
    drain(1);
    rkLog.delete();
    send(2, CT128, 1'b1, 2'd0, PT, 1, 0);
    drain(2);
    chk("t2_rkseq_len", 128'(rkLog.size()), 128'd44);
    for (int i = 0; i < 44; i++)
      chk($sformatf("t2_rkidx_%0d", i), 128'(i < rkLog.size() ? rkLog[i] : 6'h3f), 128'(4 * (10 - i / 4) + i % 4));
    expandKey(8);
    send(3, PT, 1'b0, 2'd2, CT256, 1, 0);
    drain(3);
    send(8, CT256, 1'b1, 2'd2, PT, 1, 0);
    drain(8);
    expandKey(6);
    send(7, PT, 1'b0, 2'd1, CT192, 1, 1);
    drain(7);
    expandKey(4);
    send(9, PT, 1'b0, 2'd3, CT128, 1, 0);
    drain(9);
    OutReady = 0;
    send(4, PT, 1'b0, 2'd0, CT128, 1, 0);
    n = 0;
    while (!OutValid && n < 100) begin step(); n++; end
    for (int i = 0; i < 20; i++) begin
      chk("t4_hold_valid", 128'(OutValid), 128'd1);
      chk("t4_hold_block", OutBlock, CT128);
      chk("t4_hold_inready", 128'(InReady), 128'd0);
      InValid = i[0];
      InBlock = CT128;
      step();
    end
    InValid = 0;
    OutReady = 1;
    chk("t4_release_inready", 128'(InReady), 128'd0);
    step();
    chk("t4_after_inready", 128'(InReady), 128'd1);
    chk("t4_after_busy", 128'(Busy), 128'd0);
    send(10, CT128, 1'b1, 2'd0, PT, 1, 0);
    drain(10);
    send(5, PT, 1'b0, 2'd0, 128'd0, 0, 0);
    n = 0;
    while (!(DpEnc && RkIdx == 6'd22) && n < 100) begin step(); n++; end
    chk("t5_at_r5c2", 128'(RkIdx), 128'd22);
    Resetn = 0;
    step();
    chk("t5_busy", 128'(Busy), 128'd0);
    chk("t5_outvalid", 128'(OutValid), 128'd0);
    chk("t5_outblock", OutBlock, 128'd0);
    chk("t5_rkidx", 128'(RkIdx), 128'd0);
    Resetn = 1;
    step();
    send(6, PT, 1'b0, 2'd0, CT128, 1, 0);
    drain(6);
    maskMode = 1;
    send(11, PT, 1'b0, 2'd0, CT128, 1, 0);
    drain(11);
    maskMode = 2;
    send(12, PT, 1'b0, 2'd0, CT128, 1, 0);
    drain(12);
    repeat (3) step();
    chk("final_queue_empty", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
